siso_shift_register: RTL and testbench

//  - Parallel-load, serial-in/serial-out shift register for the serial link datapath.
//  - Loads a parallel word, then shifts it out MSB-first one bit per enabled clock.
//  - Shifts serial_in into the LSB on the same clock.
//  - The full register contents are exposed on shift_reg for monitoring and parallel read-back.

---
 rtl/siso_pkg.sv | 13 +
 rtl/siso_shift_register.sv | 61 ++++++
 tb/tb_siso_shift_register.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/siso_pkg.sv
// -----------------------------------------------------------------------------
// siso_pkg
//   Shared definitions for the serial-link shift register.
//   SISO_DEF_WIDTH : default register width in bits
//   siso_word_t    : one default-width register word
// -----------------------------------------------------------------------------
package siso_pkg;

   localparam int SISO_DEF_WIDTH = 8;

   typedef logic [SISO_DEF_WIDTH-1:0] siso_word_t;

endpackage : siso_pkg

// File: rtl/siso_shift_register.sv
// -----------------------------------------------------------------------------
// siso_shift_register
//   Parallel-load, serial-in/serial-out shift register for the serial link
//   datapath. A loaded word leaves MSB-first, one bit per enabled clock, while
//   serial_in enters at bit 0 on the same edge.
//
//   Priority at each rising edge: reset > load > enable > hold.
//
//   Optional feature (macro SISO_PARITY_EN): adds parity_out = ^shift_reg.
//
// Ports (positional order is fixed):
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset (clears register)
//   load       in   1      parallel load strobe
//   enable     in   1      shift enable
//   data_in    in   WIDTH  parallel load word
//   shift_reg  out  WIDTH  current register contents (registered)
//   serial_out out  1      shift_reg[WIDTH-1]
//   serial_in  in   1      serial input, shifted into bit 0
//   parity_out out  1      even parity of shift_reg (SISO_PARITY_EN only)
// -----------------------------------------------------------------------------
module siso_shift_register
   import siso_pkg::*;
#(
   parameter int WIDTH = SISO_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] shift_reg,
   output logic             serial_out,
   input  logic             serial_in
`ifdef SISO_PARITY_EN
   ,
   output logic             parity_out
`endif
);

   logic [WIDTH-1:0] r_shift;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift <= '0;
      end else if (load) begin
         // Load wins over enable: no shift happens on a load edge.
         r_shift <= data_in;
      end else if (enable) begin
         r_shift <= {r_shift[WIDTH-2:0], serial_in};
      end
   end

   assign shift_reg  = r_shift;
   assign serial_out = r_shift[WIDTH-1];

`ifdef SISO_PARITY_EN
   assign parity_out = ^r_shift;
`endif

endmodule : siso_shift_register

// File: tb/tb_siso_shift_register.sv
// -----------------------------------------------------------------------------
// tb_siso_shift_register
//   Scoreboard bench for siso_shift_register (WIDTH = 8). Stimulus drives
//   inputs on the falling edge and queues the register value expected after
//   the next rising edge; a monitor pops and compares just after that edge.
//   Define SISO_PARITY_EN for both DUT and bench to check parity_out.
// -----------------------------------------------------------------------------
module tb_siso_shift_register;
   import siso_pkg::*;

   typedef struct {
      string      nm;
      siso_word_t sr;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       load;
   logic       enable;
   siso_word_t data_in;
   siso_word_t shift_reg;
   logic       serial_out;
   logic       serial_in;
`ifdef SISO_PARITY_EN
   logic       parity_out;
`endif

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   siso_shift_register #(.WIDTH(SISO_DEF_WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .enable    (enable),
      .data_in   (data_in),
      .shift_reg (shift_reg),
      .serial_out(serial_out),
      .serial_in (serial_in)
`ifdef SISO_PARITY_EN
      ,
      .parity_out(parity_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expectation per rising edge at most, consumed right after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (shift_reg !== e.sr) begin
               failures++;
               $display("FAIL %s shift_reg: got %h expected %h", e.nm, shift_reg, e.sr);
            end
            checks++;
            if (serial_out !== e.sr[7]) begin
               failures++;
               $display("FAIL %s serial_out: got %b expected %b", e.nm, serial_out, e.sr[7]);
            end
`ifdef SISO_PARITY_EN
            checks++;
            if (parity_out !== (^e.sr)) begin
               failures++;
               $display("FAIL %s parity_out: got %b expected %b", e.nm, parity_out, ^e.sr);
            end
`endif
         end
      end
   end

   task automatic step(input logic r, input logic l, input logic en,
                       input siso_word_t d, input logic si,
                       input logic chk, input siso_word_t exp_sr, input string nm);
      exp_t e;
      @(negedge clk);
      reset     = r;
      load      = l;
      enable    = en;
      data_in   = d;
      serial_in = si;
      if (chk) begin
         e.nm = nm;
         e.sr = exp_sr;
         q.push_back(e);
      end
   endtask

   // Hand-computed tables
   siso_word_t a5_shift[8] = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
   siso_word_t fill_seq[8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

   initial begin
      int unsigned wait_cycles;
      reset = 1'b0; load = 1'b0; enable = 1'b0; data_in = '0; serial_in = 1'b0;

      // Reset: two cycles with data_in all ones
      step(1, 0, 0, 8'hFF, 0, 1, 8'h00, "reset1");
      step(1, 0, 0, 8'hFF, 0, 1, 8'h00, "reset2");

      // Load A5, then shift out 8 bits with zeros entering
      step(0, 1, 0, 8'hA5, 0, 1, 8'hA5, "load_a5");
      for (int i = 0; i < 8; i++)
         step(0, 0, 1, 8'h00, 0, 1, a5_shift[i], $sformatf("shift_a5_%0d", i));

      // Serial fill from zero with ones
      for (int i = 0; i < 8; i++)
         step(0, 0, 1, 8'h00, 1, 1, fill_seq[i], $sformatf("fill_%0d", i));

      // Priority: load beats enable; reset beats load
      step(0, 1, 1, 8'h3C, 1, 1, 8'h3C, "load_over_enable");
      step(1, 1, 1, 8'hFF, 1, 1, 8'h00, "reset_over_load");

      // Hold / stall
      step(0, 1, 0, 8'h81, 0, 1, 8'h81, "load_81");
      step(0, 0, 1, 8'h55, 0, 1, 8'h02, "shift_81");
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 8'h55, 1, 1, 8'h02, $sformatf("hold_%0d", i));

      // Parity pattern (parity checked only when the feature is built in)
      step(0, 1, 0, 8'h07, 0, 1, 8'h07, "load_07");
      step(0, 0, 1, 8'h00, 1, 1, 8'h0F, "shift_07");

      // Reset mid-shift after a stall
      step(0, 0, 0, 8'h00, 0, 1, 8'h0F, "hold_0f");
      step(1, 0, 1, 8'h00, 1, 1, 8'h00, "reset_mid");

      step(0, 0, 0, 8'h00, 0, 0, 8'h00, "idle");

      wait_cycles = 0;
      while (q.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_siso_shift_register
